fjk_bank: RTL



---
 rtl/fjk_bank.sv | 77 +++++++
 1 files changed

// File: rtl/fjk_bank.sv
// fjk_bank: WIDTH-bit bank of JK flip-flops with per-bit active-low clear and up/down count mode.
// Define MCLOCK_EDGE_EN to advance on rising edges of clk instead of while clk is high.
module fjk_bank #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             MasterClock,
    input  logic             reset,
    input  logic             clk,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] rL,
    input  logic             cnt_en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qL,
    output logic             tc
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] cnt_val;
    logic             act;

`ifdef MCLOCK_EDGE_EN
    logic old_clk_reg;

    // Held at 1 through reset so a clk already high at release is not an edge.
    always_ff @(posedge MasterClock or posedge reset) begin
        if (reset) begin
            old_clk_reg <= 1'b1;
        end else begin
            old_clk_reg <= clk;
        end
    end

    assign act = clk & ~old_clk_reg;
`else
    assign act = clk;
`endif

    assign cnt_val = up ? (q_reg + WIDTH'(1)) : (q_reg - WIDTH'(1));

    // Clear dominates every other condition, including an inactive strobe.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic jk_bit;

            always_comb begin
                jk_bit = q_reg[gi];
                case ({j[gi], k[gi]})
                    2'b00:   jk_bit = q_reg[gi];
                    2'b01:   jk_bit = 1'b0;
                    2'b10:   jk_bit = 1'b1;
                    default: jk_bit = ~q_reg[gi];
                endcase
            end

            assign q_next[gi] = !rL[gi] ? 1'b0 :
                                !act    ? q_reg[gi] :
                                cnt_en  ? cnt_val[gi] : jk_bit;
        end
    endgenerate

    always_ff @(posedge MasterClock or posedge reset) begin
        if (reset) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q  = q_reg;
    assign qL = ~q_reg;
    assign tc = cnt_en & (up ? (&q_reg) : ~(|q_reg));

endmodule
